// File: rtl/int2flt_if.sv
// Start/done handshake bundle for the int2flt_seq converter.
// The controller side uses the master modport; the converter uses slave.
interface int2flt_if #(
    parameter int INT_W = 16,
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    logic                   start;
    logic [INT_W-1:0]       int_in;
    logic [EXP_W+MAN_W:0]   flt_out;
    logic                   busy;
    logic                   done;
    logic                   ovf;

    modport master (output start, int_in, input flt_out, busy, done, ovf);
    modport slave  (input start, int_in, output flt_out, busy, done, ovf);
endinterface

// File: rtl/int2flt_seq.sv
// Multi-cycle integer-to-float converter with a one-bit-per-cycle normaliser.
// Define INT2FLT_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module int2flt_seq #(
    parameter int INT_W  = 16,
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int BIAS   = 15,
    parameter int SIGNED = 1
) (
    input  logic      clk,
    input  logic      rst,
    int2flt_if.slave  bus
);
    localparam int FLT_W = 1 + EXP_W + MAN_W;
    localparam int E_A   = EXP_W + 2;
    localparam int E_B   = $clog2(BIAS + INT_W + 1) + 1;
    localparam int E_W   = (E_A > E_B) ? E_A : E_B;
    localparam logic [E_W-1:0] EXP_INIT = E_W'(BIAS + INT_W - 1);
    localparam logic [E_W-1:0] EXP_MAX  = E_W'((2 ** EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

    state_t             st_r;
    logic               sign_r;
    logic [INT_W-1:0]   mag_r;
    logic [E_W-1:0]     exp_r;
    logic [FLT_W-1:0]   flt_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

    logic               in_sign_s;
    logic [INT_W-1:0]   in_mag_s;
    logic [MAN_W-1:0]   frac_s;
    logic               rnd_up_s;
    logic [MAN_W:0]     frac_sum_s;
    logic [MAN_W-1:0]   frac_fin_s;
    logic [E_W-1:0]     exp_fin_s;
    logic [FLT_W-1:0]   pack_flt_s;
    logic               pack_ovf_s;
`ifdef INT2FLT_RNE_EN
    logic [INT_W:0]     rem_s;
`endif

    // Operand sign/magnitude; the most-negative value wraps to 2^(INT_W-1) as intended.
    always_comb begin
        in_sign_s = 1'b0;
        in_mag_s  = bus.int_in;
        if (SIGNED != 0) begin
            in_sign_s = bus.int_in[INT_W-1];
        end else begin
            in_sign_s = 1'b0;
        end
        if (in_sign_s) begin
            in_mag_s = -bus.int_in;
        end else begin
            in_mag_s = bus.int_in;
        end
    end

    // Fraction extraction, optional rounding and final packing of the normalised magnitude.
    always_comb begin
        // The padded shift gives zero-fill on the right when INT_W-1 < MAN_W.
        frac_s   = MAN_W'({mag_r[INT_W-2:0], {(MAN_W+2){1'b0}}} >> (INT_W + 1));
        rnd_up_s = 1'b0;
`ifdef INT2FLT_RNE_EN
        rem_s    = (INT_W+1)'({mag_r[INT_W-2:0], {(MAN_W+2){1'b0}}});
        rnd_up_s = rem_s[INT_W] & ((|rem_s[INT_W-1:0]) | frac_s[0]);
`endif
        frac_sum_s = {1'b0, frac_s} + {{MAN_W{1'b0}}, rnd_up_s};
        if (frac_sum_s[MAN_W]) begin
            frac_fin_s = {MAN_W{1'b0}};
            exp_fin_s  = exp_r + E_W'(1);
        end else begin
            frac_fin_s = frac_sum_s[MAN_W-1:0];
            exp_fin_s  = exp_r;
        end
        if (mag_r == {INT_W{1'b0}}) begin
            pack_flt_s = {FLT_W{1'b0}};
            pack_ovf_s = 1'b0;
        end else if (exp_fin_s >= EXP_MAX) begin
            pack_flt_s = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_ovf_s = 1'b1;
        end else begin
            pack_flt_s = {sign_r, exp_fin_s[EXP_W-1:0], frac_fin_s};
            pack_ovf_s = 1'b0;
        end
    end

    // Control FSM with registered result and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_r   <= IDLE;
            sign_r <= 1'b0;
            mag_r  <= {INT_W{1'b0}};
            exp_r  <= {E_W{1'b0}};
            flt_r  <= {FLT_W{1'b0}};
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (st_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sign_r <= in_sign_s;
                        mag_r  <= in_mag_s;
                        exp_r  <= EXP_INIT;
                        busy_r <= 1'b1;
                        st_r   <= (in_mag_s == {INT_W{1'b0}}) ? PACK : NORM;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                NORM: begin
                    if (mag_r[INT_W-1]) begin
                        st_r <= PACK;
                    end else begin
                        mag_r <= {mag_r[INT_W-2:0], 1'b0};
                        exp_r <= exp_r - E_W'(1);
                    end
                end
                PACK: begin
                    flt_r  <= pack_flt_s;
                    ovf_r  <= pack_ovf_s;
                    done_r <= 1'b1;
                    st_r   <= DONE;
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    st_r   <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    st_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.flt_out = flt_r;
    assign bus.ovf     = ovf_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
endmodule

// File: tb/tb_int2flt_seq.sv
// Self-checking bench for int2flt_seq: directed table, randomized model checks, control corners.
// Expectations follow INT2FLT_RNE_EN when it is defined for the build.
module tb_int2flt_seq;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    int2flt_if #(.INT_W(16), .EXP_W(5), .MAN_W(10)) ifa ();
    int2flt_if #(.INT_W(16), .EXP_W(5), .MAN_W(10)) ifb ();

    int2flt_seq #(.INT_W(16), .EXP_W(5), .MAN_W(10), .BIAS(15), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .bus(ifa));
    int2flt_seq #(.INT_W(16), .EXP_W(5), .MAN_W(10), .BIAS(15), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;
        logic [15:0] val;
        logic [15:0] flt;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Reference: value-level conversion using integer arithmetic on the magnitude.
    function automatic void model(input logic [15:0] v, input bit sgn,
                                  output logic [15:0] f, output logic o, output int lat);
        longint mag, sc, q, r;
        int p, e;
        bit s;
`ifdef INT2FLT_RNE_EN
        longint half;
`endif
        s   = sgn && v[15];
        mag = s ? (longint'(65536) - longint'(v)) : longint'(v);
        if (mag == 0) begin
            f = 16'h0000; o = 1'b0; lat = 2;
            return;
        end
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        lat = 18 - p;
        sc  = mag << 10;
        q   = sc >> p;
        r   = sc - (q << p);
`ifdef INT2FLT_RNE_EN
        half = longint'(1) << p;
        if ((2 * r > half) || ((2 * r == half) && (q % 2 == 1))) q = q + 1;
`endif
        e = 15 + p;
        if (q == 2048) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 31) begin
            f = {s, 5'h1F, 10'h000}; o = 1'b1;
        end else begin
            f = {s, 5'(e), 10'(q - 1024)}; o = 1'b0;
        end
    endfunction

    task automatic set_in(input bit sel, input logic st, input logic [15:0] v);
        if (sel) begin ifb.start = st; ifb.int_in = v; end
        else     begin ifa.start = st; ifa.int_in = v; end
    endtask

    // One conversion; glitch > 0 re-pulses start at that cycle after acceptance.
    task automatic run(input bit sel, input logic [15:0] v, input logic [15:0] ef,
                       input logic eo, input int el, input int glitch, input string nm);
        int  n;
        bit  seen, busy_ok;
        logic [15:0] fo;
        logic        oo;
        @(negedge clk);
        set_in(sel, 1'b1, v);
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if ((sel ? ifb.busy : ifa.busy) !== 1'b1) busy_ok = 1'b0;
            if ((sel ? ifb.done : ifa.done) === 1'b1) seen = 1'b1;
            set_in(sel, (n == glitch) ? 1'b1 : 1'b0, 16'($urandom));
        end
        set_in(sel, 1'b0, 16'h0000);
        fo = sel ? ifb.flt_out : ifa.flt_out;
        oo = sel ? ifb.ovf : ifa.ovf;
        chk({nm, " latency"}, 32'(seen ? n : -1), 32'(el));
        chk({nm, " flt_out"}, {16'h0, fo}, {16'h0, ef});
        chk({nm, " ovf"}, {31'h0, oo}, {31'h0, eo});
        chk({nm, " busy"}, {31'h0, busy_ok}, 32'h1);
    endtask

    initial begin
        logic [15:0] v, ef;
        logic        eo;
        int          el;
        bit          sel;
        bit          done_seen;
        n_chk = 0; n_fail = 0;
        rst = 1'b0;
        set_in(1'b0, 1'b0, 16'h0000);
        set_in(1'b1, 1'b0, 16'h0000);
        #1;
        chk("reset flt_out", {16'h0, ifa.flt_out}, 32'h0);
        chk("reset busy/done/ovf", {29'h0, ifa.busy, ifa.done, ifa.ovf}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

`ifdef INT2FLT_RNE_EN
        vecs[3] = '{1'b0, 16'h7FFF, 16'h7800, 1'b0, 4};
        vecs[5] = '{1'b0, 16'h0803, 16'h6802, 1'b0, 7};
        vecs[6] = '{1'b1, 16'hFFFF, 16'h7C00, 1'b1, 3};
`else
        vecs[3] = '{1'b0, 16'h7FFF, 16'h77FF, 1'b0, 4};
        vecs[5] = '{1'b0, 16'h0803, 16'h6801, 1'b0, 7};
        vecs[6] = '{1'b1, 16'hFFFF, 16'h7BFF, 1'b0, 3};
`endif
        vecs[0] = '{1'b0, 16'h0003, 16'h4200, 1'b0, 17};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 2};
        vecs[2] = '{1'b0, 16'h8000, 16'hF800, 1'b0, 3};
        vecs[4] = '{1'b0, 16'h0801, 16'h6800, 1'b0, 7};
        vecs[7] = '{1'b0, 16'hFFFF, 16'hBC00, 1'b0, 18};
        vecs[8] = '{1'b1, 16'h0001, 16'h3C00, 1'b0, 18};
        for (int i = 0; i < 9; i++)
            run(vecs[i].sel, vecs[i].val, vecs[i].flt, vecs[i].ovf, vecs[i].lat, 0,
                $sformatf("vec%0d", i));

        // start re-pulsed mid-NORM is ignored
        run(1'b0, 16'h0003, 16'h4200, 1'b0, 17, 5, "glitch");

        // start held during the done cycle is ignored
        set_in(1'b0, 1'b1, 16'h0005);
        @(negedge clk);
        chk("start in DONE busy", {31'h0, ifa.busy}, 32'h0);
        set_in(1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("start in DONE idle", {30'h0, ifa.busy, ifa.done}, 32'h0);
        chk("start in DONE flt", {16'h0, ifa.flt_out}, 32'h4200);

        // reset mid-NORM aborts without a done pulse
        set_in(1'b0, 1'b1, 16'h0003);
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort flt_out", {16'h0, ifa.flt_out}, 32'h0);
        chk("abort busy/done/ovf", {29'h0, ifa.busy, ifa.done, ifa.ovf}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ifa.done === 1'b1 || ifa.busy === 1'b1) done_seen = 1'b1;
        end
        chk("abort no done", {31'h0, done_seen}, 32'h0);
        run(1'b0, 16'h0003, 16'h4200, 1'b0, 17, 0, "after abort");

        // randomized against the reference model, both signedness modes
        for (int i = 0; i < 200; i++) begin
            sel = 1'($urandom_range(0, 1));
            v   = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) v = -v;
            model(v, !sel, ef, eo, el);
            run(sel, v, ef, eo, el, (i % 7 == 0) ? 2 : 0, $sformatf("rnd%0d v=%h", i, v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/int2flt_seq.md
Name: int2flt_seq

Overview:
- Parametrised, multi-cycle integer-to-floating-point converter. Successor to the fixed 16-bit int2flt program.
- Accepts a signed or unsigned INT_W-bit integer and produces a 1+EXP_W+MAN_W-bit float (sign | biased exponent | fraction, hidden leading 1).
- Uses an iterative one-bit-per-cycle normaliser.
- Sits beside the datapath as a start/done accelerator, driven by the top-level controller in place of the software conversion loop.

Parameters:
INT_W, 16, integer input width (>=2)
EXP_W, 5, exponent field width
MAN_W, 10, fraction field width (hidden bit excluded)
BIAS, 15, exponent bias
SIGNED, 1, 1 = two's-complement input; 0 = unsigned input

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
int_in  input  INT_W  operand; sampled on the accepted start cycle only
flt_out  output  1+EXP_W+MAN_W  result; held until the next accepted start
busy  output  1  high in every state except IDLE
done  output  1  single-cycle pulse, in the DONE state
ovf  output  1  exponent overflow on the last result; held like flt_out

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; flt_out=0, busy=0, done=0, ovf=0; internal registers cleared. Reset mid-conversion aborts it; no done pulse is produced.
- States: IDLE, NORM, PACK, DONE.
- IDLE, start=1 (accept, cycle T):
  - sign = SIGNED ? int_in[INT_W-1] : 0.
  - mag = sign ? -int_in : int_in, as an INT_W-bit unsigned value. The most-negative input yields mag = 2^(INT_W-1) with no overflow.
  - exp = BIAS+INT_W-1, in an internal register at least EXP_W+2 bits wide.
  - Next state: PACK if mag==0, else NORM.
- NORM: if mag[INT_W-1]==1, go to PACK. Otherwise mag<<=1, exp-=1, stay in NORM.
- PACK:
  - frac = mag[INT_W-2 : INT_W-1-MAN_W], zero-padded on the right when INT_W-1 < MAN_W.
  - Bits below frac are the round remainder (see Optional Feature).
  - If frac overflows on rounding: frac=0, exp+=1.
  - If exp >= 2^EXP_W-1: flt_out={sign, all-ones, 0} (infinity), ovf=1.
  - Else: flt_out={sign, exp[EXP_W-1:0], frac}, ovf=0.
  - mag==0: flt_out=0 (positive zero), ovf=0.
  - flt_out and ovf are registered at the end of PACK. Next state: DONE.
- DONE: done=1 for exactly one cycle; next state IDLE. flt_out is valid during done.
- Latency: with k = leading zeros of mag (0..INT_W-1), done is high in cycle T+k+3. Zero input: done in T+2.
- start while busy: ignored; no queuing, no effect on the result.
- start asserted in the same cycle done is high: ignored. Earliest re-accept is the following IDLE cycle.
- int_in changes after acceptance: no effect.

Optional Feature:
- Macro: INT2FLT_RNE_EN.
- Defined: PACK rounds to nearest, ties to even.
  - Round up when the remainder is > half an LSB, or == half with frac[0]=1.
  - Rounding carry may bump the exponent and may produce infinity with ovf=1.
- Undefined: truncation (round toward zero); the remainder is discarded.
- Latency is identical in both builds.

Test Plan (defaults unless stated; T = accept cycle):
- 0x0003 -> flt_out=0x4200, done at T+17, ovf=0; busy high T+1..T+17.
- 0x0000 -> flt_out=0x0000, done at T+2. 0x8000 -> flt_out=0xF800, done at T+3.
- 0x7FFF -> truncation build: 0x77FF; RNE build: 0x7800.
- 0x0801 -> 0x6800 in both builds (tie, even). 0x0803 -> truncation build: 0x6801; RNE build: 0x6802.
- SIGNED=0, 0xFFFF -> truncation build: 0x7BFF, ovf=0; RNE build: 0x7C00, ovf=1.
- Control: start pulsed again mid-NORM -> ignored, result unchanged. rst driven low mid-NORM -> all outputs 0, no done. Next start of 0x0003 -> 0x4200.
